// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
// Holds the FSM state encoding, the result width and the timeout error code.
package adc_pkg;

  localparam int ADC_DW = 16;
  localparam logic [ADC_DW-1:0] ADC_ERR_CODE = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DELIVER,
    GAP
  } state_t;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or above ptr, wrapping around.
// Purely combinational, no state; gnt_vld is low when no request is set.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  always_comb begin
    dbl     = {req, req};
    // rot[i] is the request that sits i places after the pointer
    rot     = dbl[ptr +: N];
    gnt_vld = |rot;
    sum     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (IW + 1)'(i);
      end
    end
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    gnt_idx = sum[IW-1:0];
  end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Shares one serial ADC engine among NUM_REQ clients and a periodic auto channel; ack one cycle after conv_done.
// Clients hold req until ack; conversions are spaced by GAP_CYC idle cycles and guarded by a timeout.
module adc_conv_scheduler
  import adc_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 4095,
  parameter int GAP_CYC  = 40,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  ack,
  output logic [ADC_DW-1:0]   rdata,
  output logic                rerr,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [ADC_DW-1:0]   conv_data,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period_cfg,
  output logic                auto_valid,
  output logic                overrun
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int GW = $clog2(GAP_CYC + 2);

  state_t        state, nstate;
  logic          owner_auto;
  logic [IW-1:0] owner_idx;
  logic [IW-1:0] rr_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PERIOD_W-1:0] per_cnt;
  logic          auto_pend;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          per_run;
  logic          tick;
  logic          auto_clr;
  logic          tmo_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT));
  assign per_run  = auto_en && (period_cfg != '0);
  // A period shortened below the current count wraps at once instead of running to full scale
  assign tick     = per_run && (per_cnt >= period_cfg - 1'b1);
  assign auto_clr = (state == DELIVER) && owner_auto;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate     = state;
    conv_start = 1'b0;
    ack        = '0;
    auto_valid = 1'b0;
    case (state)
      IDLE: begin
        if (auto_pend || gnt_vld) begin
          nstate = START;
        end
      end
      START: begin
        conv_start = 1'b1;
        nstate     = WAIT;
      end
      WAIT: begin
        if (conv_done || tmo_hit) begin
          nstate = DELIVER;
        end
      end
      DELIVER: begin
        if (owner_auto) begin
          auto_valid = 1'b1;
        end else begin
          ack[owner_idx] = 1'b1;
        end
        nstate = GAP;
      end
      GAP: begin
        if (gap_cnt >= GW'(GAP_CYC)) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_auto <= 1'b0;
      owner_idx  <= '0;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      rdata      <= '0;
      rerr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (auto_pend) begin
            owner_auto <= 1'b1;
          end else if (gnt_vld) begin
            owner_auto <= 1'b0;
            owner_idx  <= gnt_idx;
          end
        end
        START: begin
          tmo_cnt <= '0;
        end
        WAIT: begin
          // A done pulse on the timeout cycle still delivers real data
          if (conv_done) begin
            rdata <= conv_data;
            rerr  <= 1'b0;
          end else if (tmo_hit) begin
            rdata <= ADC_ERR_CODE;
            rerr  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DELIVER: begin
          gap_cnt <= GW'(1);
          if (!owner_auto) begin
            rr_ptr <= (owner_idx == IW'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt < GW'(GAP_CYC)) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt   <= '0;
      auto_pend <= 1'b0;
      overrun   <= 1'b0;
    end else if (!per_run) begin
      per_cnt   <= '0;
      auto_pend <= 1'b0;
    end else begin
      per_cnt <= tick ? '0 : per_cnt + 1'b1;
      // A tick landing on the auto delivery re-arms without counting as lost
      if (tick) begin
        auto_pend <= 1'b1;
      end else if (auto_clr) begin
        auto_pend <= 1'b0;
      end
      if (tick && auto_pend && !auto_clr) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler with a behavioural serial-engine responder.
module tb_adc_conv_scheduler;

  localparam int NR  = 4;
  localparam int TMO = 4095;
  localparam int GAP = 40;
  localparam int PW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] ack;
  logic [15:0]   rdata;
  logic          rerr;
  logic          conv_start;
  logic          conv_done;
  logic [15:0]   conv_data;
  logic          auto_en = 1'b0;
  logic [PW-1:0] period_cfg = '0;
  logic          auto_valid;
  logic          overrun;

  logic          eng_done = 1'b0;
  logic          stray_done = 1'b0;
  logic [15:0]   eng_dat = '0;

  assign conv_done = eng_done | stray_done;
  assign conv_data = stray_done ? 16'hBEEF : eng_dat;

  adc_conv_scheduler #(
    .NUM_REQ  (NR),
    .TIMEOUT  (TMO),
    .GAP_CYC  (GAP),
    .PERIOD_W (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .ack        (ack),
    .rdata      (rdata),
    .rerr       (rerr),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .conv_data  (conv_data),
    .auto_en    (auto_en),
    .period_cfg (period_cfg),
    .auto_valid (auto_valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          frame_len = 500;
  bit          eng_mute = 1'b0;
  bit          eng_fixed = 1'b1;
  logic [15:0] eng_val = 16'h1234;
  int          remain = 0;
  int          n_start = 0;
  int          last_start = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          min_space = 1000000;

  // Engine model: answers each start pulse frame_len cycles later
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (!rst_n) begin
      remain = 0;
    end else if (conv_start) begin
      if (n_start > 0 && (cyc - last_start) < min_space) min_space = cyc - last_start;
      n_start++;
      last_start = cyc;
      start_cyc  = cyc;
      remain     = frame_len;
    end else if (remain > 0) begin
      remain--;
      if (remain == 0 && !eng_mute) begin
        eng_done = 1'b1;
        eng_dat  = eng_fixed ? eng_val : 16'hC000 + 16'(n_start);
        done_cyc = cyc;
      end
    end
  end

  int n_evt = 0;
  int n_both = 0;
  always @(negedge clk) begin
    if (ack != '0 || auto_valid) n_evt++;
    if (ack != '0 && auto_valid) n_both++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  bit            ev_found;
  logic [NR-1:0] ev_ack;
  logic          ev_auto;
  logic [15:0]   ev_dat;
  logic          ev_err;
  int            ev_cyc;

  task automatic wait_evt(input string tag, input int budget);
    ev_found = 1'b0;
    for (int i = 0; i < budget && !ev_found; i++) begin
      @(negedge clk);
      if (ack != '0 || auto_valid) begin
        ev_found = 1'b1;
        ev_ack   = ack;
        ev_auto  = auto_valid;
        ev_dat   = rdata;
        ev_err   = rerr;
        ev_cyc   = cyc;
      end
    end
    chk(tag, 32'(ev_found), 32'd1);
  endtask

  int e0, s0, t0, a1, a2, n_auto, lat;
  bit auto_err, auto_ack;
  int rr_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_flags", 32'({rerr, conv_start, auto_valid, overrun}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 32'(n_start), 32'd0);

    // Single client, 500-cycle frame
    req = 4'b0010;
    wait_evt("single_evt", 700);
    req = '0;
    chk("single_ack", 32'(ev_ack), 32'b0010);
    chk("single_rdata", 32'(ev_dat), 32'h1234);
    chk("single_rerr", 32'(ev_err), 32'd0);
    chk("single_done_to_ack", 32'(ev_cyc - done_cyc), 32'd1);
    chk("single_start_to_ack", 32'(ev_cyc - start_cyc), 32'd501);
    chk("single_nstart", 32'(n_start), 32'd1);

    // Stray conv_done in GAP, then in IDLE
    repeat (5) @(negedge clk);
    e0 = n_evt;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (60) @(negedge clk);
    chk("stray_gap_noevt", 32'(n_evt - e0), 32'd0);
    chk("stray_gap_rdata", 32'(rdata), 32'h1234);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("stray_idle_noevt", 32'(n_evt - e0), 32'd0);
    chk("stray_idle_rdata", 32'(rdata), 32'h1234);
    chk("stray_nstart", 32'(n_start), 32'd1);

    // Client 3 moves the pointer back to 0
    frame_len = 20;
    eng_fixed = 1'b0;
    req = 4'b1000;
    wait_evt("c3_evt", 200);
    req = '0;
    chk("c3_ack", 32'(ev_ack), 32'b1000);
    chk("c3_rdata", 32'(ev_dat), 32'hC002);

    // Round-robin with all four requesting; req0 re-raised after ack1
    min_space = 1000000;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_evt("rr_evt", 200);
      chk("rr_ack", 32'(ev_ack), 32'(1 << rr_order[k]));
      chk("rr_rdata", 32'(ev_dat), 32'(16'hC003 + k));
      req[rr_order[k]] = 1'b0;
      if (k == 1) req[0] = 1'b1;
    end
    chk("rr_spacing", 32'(min_space >= GAP + 20), 32'd1);

    // Timeout: engine never answers; pointer is 1 so client 2 is next
    eng_mute = 1'b1;
    req = 4'b0100;
    wait_evt("tmo_evt", 4400);
    req = '0;
    eng_mute = 1'b0;
    lat = ev_cyc - start_cyc;
    chk("tmo_ack", 32'(ev_ack), 32'b0100);
    chk("tmo_rdata", 32'(ev_dat), 32'hFFFF);
    chk("tmo_rerr", 32'(ev_err), 32'd1);
    chk("tmo_latency", 32'(lat >= TMO && lat <= TMO + 4), 32'd1);
    req = 4'b0001;
    wait_evt("post_tmo_evt", 200);
    req = '0;
    chk("post_tmo_ack", 32'(ev_ack), 32'b0001);
    chk("post_tmo_rdata", 32'(ev_dat), 32'hC009);
    chk("post_tmo_rerr", 32'(ev_err), 32'd0);

    // Auto channel ahead of busy clients
    repeat (50) @(negedge clk);
    frame_len = 200;
    req = 4'b1111;
    auto_en = 1'b1;
    period_cfg = 16'd3000;
    t0 = cyc;
    n_auto = 0;
    a1 = 0;
    a2 = 0;
    auto_err = 1'b0;
    auto_ack = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (auto_valid) begin
        n_auto++;
        if (n_auto == 1) a1 = cyc;
        else a2 = cyc;
        auto_err = auto_err | rerr;
        auto_ack = auto_ack | (ack != '0);
      end
    end
    chk("auto_count", 32'(n_auto), 32'd2);
    chk("auto_first", 32'((a1 - t0) >= 3000 && (a1 - t0) <= 3500), 32'd1);
    chk("auto_period", 32'((a2 - a1) >= 2700 && (a2 - a1) <= 3300), 32'd1);
    chk("auto_rerr", 32'(auto_err), 32'd0);
    chk("auto_no_ack", 32'(auto_ack), 32'd0);
    chk("auto_no_overrun", 32'(overrun), 32'd0);

    period_cfg = 16'd100;
    repeat (1000) @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    auto_en = 1'b0;
    period_cfg = '0;
    req = '0;
    repeat (600) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a client conversion
    eng_fixed = 1'b1;
    eng_val = 16'h5A5A;
    frame_len = 500;
    s0 = n_start;
    req = 4'b1000;
    for (int i = 0; i < 100 && n_start == s0; i++) @(negedge clk);
    chk("rst_mid_started", 32'(n_start - s0), 32'd1);
    repeat (100) @(negedge clk);
    chk("pre_rst_rdata_nz", 32'(rdata != '0), 32'd1);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    chk("mid_rst_flags", 32'({rerr, conv_start, auto_valid, overrun}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = n_evt;
    s0 = n_start;
    repeat (700) @(negedge clk);
    chk("post_rst_noevt", 32'(n_evt - e0), 32'd0);
    chk("post_rst_nostart", 32'(n_start - s0), 32'd0);
    req = 4'b0001;
    wait_evt("post_rst_evt", 700);
    req = '0;
    chk("post_rst_ack", 32'(ev_ack), 32'b0001);
    chk("post_rst_rdata", 32'(ev_dat), 32'h5A5A);
    chk("post_rst_rerr", 32'(ev_err), 32'd0);

    chk("ack_auto_exclusive", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
